// File: rtl/weight_buf_pkg.sv
// weight_buf_pkg: shared sizing constants and write-FSM state type for the weight ping-pong buffer
package weight_buf_pkg;
    localparam int DATA_W = 6144;
    localparam int DEPTH  = 16;
    localparam int PTR_W  = $clog2(DEPTH);
    typedef enum logic [1:0] {FILL, LOADED, SWAP} state_t;
endpackage

// File: rtl/weight_pingpong_buf_if.sv
// weight_pingpong_buf_if: upstream row stream (s_axis_*) and read port (rd_*) of the weight buffer
// ports: master = packer/array side driving tdata/tvalid/tlast and rd_en/rd_addr; slave = buffer side
interface weight_pingpong_buf_if #(
    parameter int DATA_W = weight_buf_pkg::DATA_W,
    parameter int PTR_W  = weight_buf_pkg::PTR_W
);
    logic [DATA_W-1:0] s_axis_tdata;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic [3:0]        s_axis_tlast;
    logic              rd_en;
    logic [PTR_W-1:0]  rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    modport master (output s_axis_tdata, s_axis_tvalid, s_axis_tlast, rd_en, rd_addr,
                    input  s_axis_tready, rd_data, rd_valid);
    modport slave  (input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, rd_en, rd_addr,
                    output s_axis_tready, rd_data, rd_valid);
endinterface

// File: rtl/pingpong_bank.sv
// pingpong_bank: DEPTH x DATA_W simple dual-port RAM, sync write, registered read that holds when re=0
// ports: clk, rst (clears only the read register), we/wr_addr/wr_data, re/rd_addr -> rd_data
module pingpong_bank #(
    parameter int DATA_W = weight_buf_pkg::DATA_W,
    parameter int DEPTH  = weight_buf_pkg::DEPTH,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [PTR_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              re,
    input  logic [PTR_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[wr_addr] <= wr_data;
    always_ff @(posedge clk)
        if (rst) rd_data <= '0;
        else if (re) rd_data <= mem[rd_addr];
endmodule

// File: rtl/weight_pingpong_buf.sv
// weight_pingpong_buf: two-bank weight buffer; upstream fills bank ~bank_sel while the array reads bank_sel
// ports: clk, rst, bus (row stream + read port), weight_switch_in, array_idle,
//        bank_sel, weights_valid, active_rows, overflow_err
module weight_pingpong_buf #(
    parameter int DATA_W = weight_buf_pkg::DATA_W,
    parameter int DEPTH  = weight_buf_pkg::DEPTH,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    weight_pingpong_buf_if.slave bus,
    input  logic                 weight_switch_in,
    input  logic                 array_idle,
    output logic                 bank_sel,
    output logic                 weights_valid,
    output logic [PTR_W:0]       active_rows,
    output logic                 overflow_err
);
    import weight_buf_pkg::*;
    state_t            state, state_nx;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W:0]    wr_cnt;
    logic              switch_pend, accept, last_beat, rd_valid, rd_sel;
    logic [DATA_W-1:0] q0, q1;
    assign bus.s_axis_tready = (state == FILL) & ~rst;
    assign accept    = bus.s_axis_tvalid & bus.s_axis_tready;
    // a beat in the final row slot closes the load even without tlast
    assign last_beat = accept & ((|bus.s_axis_tlast) | (wr_ptr == PTR_W'(DEPTH-1)));
    always_comb begin
        state_nx = state;
        state_nx = (state == FILL)   ? (last_beat ? LOADED : FILL) :
                   (state == LOADED) ? ((switch_pend & array_idle) ? SWAP : LOADED) : FILL;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= FILL;
            wr_ptr        <= '0;
            wr_cnt        <= '0;
            switch_pend   <= 1'b0;
            bank_sel      <= 1'b0;
            weights_valid <= 1'b0;
            active_rows   <= '0;
            overflow_err  <= 1'b0;
        end else begin
            state       <= state_nx;
            // a fresh pulse in the swap-entry cycle is kept for the next load
            switch_pend <= weight_switch_in | (switch_pend & (state_nx != SWAP));
            if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
            if (last_beat) wr_cnt <= {1'b0, wr_ptr} + (PTR_W+1)'(1);
            if (last_beat & ~(|bus.s_axis_tlast)) overflow_err <= 1'b1;
            if (state == SWAP) begin
                bank_sel      <= ~bank_sel;
                active_rows   <= wr_cnt;
                weights_valid <= 1'b1;
                wr_ptr        <= '0;
            end
        end
    end
    // rd_sel remembers which bank served the last read, so a read in the SWAP cycle returns old-bank data
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_sel   <= 1'b0;
        end else begin
            rd_valid <= bus.rd_en;
            if (bus.rd_en) rd_sel <= bank_sel;
        end
    end
    assign bus.rd_valid = rd_valid;
    assign bus.rd_data  = rd_sel ? q1 : q0;
    pingpong_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_bank0 (
        .clk(clk), .rst(rst),
        .we(accept & bank_sel), .wr_addr(wr_ptr), .wr_data(bus.s_axis_tdata),
        .re(bus.rd_en & ~bank_sel), .rd_addr(bus.rd_addr), .rd_data(q0)
    );
    pingpong_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_bank1 (
        .clk(clk), .rst(rst),
        .we(accept & ~bank_sel), .wr_addr(wr_ptr), .wr_data(bus.s_axis_tdata),
        .re(bus.rd_en & bank_sel), .rd_addr(bus.rd_addr), .rd_data(q1)
    );
endmodule
